// File: rtl/mul8_err_pkg.sv
// Shared types and helpers for the 8x8 approximate-multiplier error monitor.
package mul8_err_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Saturating add into a w-bit accumulator (w <= 63). Bit 64 of the result
  // flags that the true sum exceeded 2^w-1; the low bits hold the clamped sum.
  function automatic logic [64:0] sat_add(input logic [63:0] acc,
                                          input logic [63:0] inc,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, acc} + {1'b0, inc};
    lim = (65'd1 << w) - 65'd1;
    if (sum > lim) return {1'b1, lim[63:0]};
    return {1'b0, sum[63:0]};
  endfunction

endpackage

// File: rtl/mul8_abs_err.sv
// Stage 1 of the error monitor: recomputes the exact 8x8 product and registers
// the absolute error against the approximate product, with the operands.
module mul8_abs_err
  import mul8_err_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic [PROD_W-1:0] in_p,
  output logic              out_valid,
  output logic [OP_W-1:0]   out_a,
  output logic [OP_W-1:0]   out_b,
  output logic [PROD_W-1:0] out_abs_err
);

  logic [PROD_W-1:0] exact;
  logic              valid_d, valid_q;
  logic [OP_W-1:0]   a_d, a_q, b_d, b_q;
  logic [PROD_W-1:0] abs_d, abs_q;

  // Exact product and magnitude of the difference; data held when idle.
  always_comb begin
    exact   = PROD_W'(in_a) * PROD_W'(in_b);
    valid_d = in_valid;
    a_d     = a_q;
    b_d     = b_q;
    abs_d   = abs_q;
    if (in_valid) begin
      a_d   = in_a;
      b_d   = in_b;
      abs_d = (exact >= in_p) ? (exact - in_p) : (in_p - exact);
    end
  end

  // Stage 1 pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      abs_q   <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      abs_q   <= abs_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_a       = a_q;
  assign out_b       = b_q;
  assign out_abs_err = abs_q;

endmodule

// File: rtl/mul8_err_monitor.sv
// Error-characterisation stage for an approximate 8x8 multiplier: accumulates
// sum/max/count of absolute error over a window of n_samples samples.
// Optional: define MUL8_ERR_MSE_EN to add sum_sq_err / sq_sat.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting samples until n_samples handshakes
// DRAIN | waiting for the stage-1 register to empty
// DONE  | statistics final and held; start opens a new window
module mul8_err_monitor
  import mul8_err_pkg::*;
#(
  parameter int SUM_W = 32,
  parameter int CNT_W = 17
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_samples,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic [PROD_W-1:0] in_p,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum_abs_err,
  output logic              sum_sat,
  output logic [PROD_W-1:0] max_abs_err,
  output logic [OP_W-1:0]   worst_a,
  output logic [OP_W-1:0]   worst_b,
  output logic [CNT_W-1:0]  err_count,
`ifdef MUL8_ERR_MSE_EN
  output logic [SUM_W+15:0] sum_sq_err,
  output logic              sq_sat,
`endif
  output logic [CNT_W-1:0]  sample_count
);

  state_e            state_d, state_q;
  logic [CNT_W-1:0]  n_d, n_q, acc_d, acc_q;
  logic [SUM_W-1:0]  sum_d, sum_q;
  logic              sat_d, sat_q;
  logic [PROD_W-1:0] max_d, max_q;
  logic [OP_W-1:0]   wa_d, wa_q, wb_d, wb_q;
  logic [CNT_W-1:0]  errc_d, errc_q, cnt_d, cnt_q;
  logic              clr;
  logic              accept;
  logic [64:0]       sum_res;

  logic              s1_valid;
  logic [OP_W-1:0]   s1_a, s1_b;
  logic [PROD_W-1:0] s1_abs;

`ifdef MUL8_ERR_MSE_EN
  localparam int SQ_W = SUM_W + 16;
  logic [SQ_W-1:0]       sq_d, sq_q;
  logic                  sqs_d, sqs_q;
  logic [2*PROD_W-1:0]   sq_inc;
  logic [64:0]           sq_res;
`endif

  assign in_ready = (state_q == RUN) && (acc_q < n_q);
  assign accept   = in_valid && in_ready;

  mul8_abs_err u_stage1 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (accept),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_p        (in_p),
    .out_valid   (s1_valid),
    .out_a       (s1_a),
    .out_b       (s1_b),
    .out_abs_err (s1_abs)
  );

  // Window sequencing: start latches the length, RUN counts handshakes.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    acc_d   = acc_q;
    clr     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          n_d     = n_samples;
          acc_d   = '0;
          clr     = 1'b1;
          state_d = (n_samples == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          acc_d = acc_q + CNT_W'(1);
          if (acc_q + CNT_W'(1) == n_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_valid) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage 2: fold each registered error into the window statistics.
  always_comb begin
    sum_d   = sum_q;
    sat_d   = sat_q;
    max_d   = max_q;
    wa_d    = wa_q;
    wb_d    = wb_q;
    errc_d  = errc_q;
    cnt_d   = cnt_q;
    sum_res = sat_add(64'(sum_q), 64'(s1_abs), SUM_W);
`ifdef MUL8_ERR_MSE_EN
    sq_d    = sq_q;
    sqs_d   = sqs_q;
    sq_inc  = (2*PROD_W)'(s1_abs) * (2*PROD_W)'(s1_abs);
    sq_res  = sat_add(64'(sq_q), 64'(sq_inc), SQ_W);
`endif
    if (clr) begin
      sum_d  = '0;
      sat_d  = 1'b0;
      max_d  = '0;
      wa_d   = '0;
      wb_d   = '0;
      errc_d = '0;
      cnt_d  = '0;
`ifdef MUL8_ERR_MSE_EN
      sq_d   = '0;
      sqs_d  = 1'b0;
`endif
    end else if (s1_valid) begin
      sum_d = SUM_W'(sum_res);
      sat_d = sat_q | sum_res[64];
      // Strictly greater only, so the first sample reaching the max is kept.
      if (s1_abs > max_q) begin
        max_d = s1_abs;
        wa_d  = s1_a;
        wb_d  = s1_b;
      end
      if (s1_abs != '0) errc_d = errc_q + CNT_W'(1);
      cnt_d = cnt_q + CNT_W'(1);
`ifdef MUL8_ERR_MSE_EN
      sq_d  = SQ_W'(sq_res);
      sqs_d = sqs_q | sq_res[64];
`endif
    end
  end

  // State and statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      sat_q   <= 1'b0;
      max_q   <= '0;
      wa_q    <= '0;
      wb_q    <= '0;
      errc_q  <= '0;
      cnt_q   <= '0;
`ifdef MUL8_ERR_MSE_EN
      sq_q    <= '0;
      sqs_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      sat_q   <= sat_d;
      max_q   <= max_d;
      wa_q    <= wa_d;
      wb_q    <= wb_d;
      errc_q  <= errc_d;
      cnt_q   <= cnt_d;
`ifdef MUL8_ERR_MSE_EN
      sq_q    <= sq_d;
      sqs_q   <= sqs_d;
`endif
    end
  end

  assign busy         = (state_q == RUN) || (state_q == DRAIN);
  assign done         = (state_q == DONE);
  assign sum_abs_err  = sum_q;
  assign sum_sat      = sat_q;
  assign max_abs_err  = max_q;
  assign worst_a      = wa_q;
  assign worst_b      = wb_q;
  assign err_count    = errc_q;
  assign sample_count = cnt_q;
`ifdef MUL8_ERR_MSE_EN
  assign sum_sq_err   = sq_q;
  assign sq_sat       = sqs_q;
`endif

endmodule

// File: tb/tb_mul8_err_monitor.sv
// Scoreboard bench for mul8_err_monitor: a 32-bit and a 16-bit accumulator
// instance share stimulus; window results are predicted from the sample list.
module tb_mul8_err_monitor;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [16:0] n_samples;
  logic [7:0]  in_a, in_b;
  logic [15:0] in_p;

  logic        in_ready, busy, done, sum_sat;
  logic [31:0] sum_abs_err;
  logic [15:0] max_abs_err;
  logic [7:0]  worst_a, worst_b;
  logic [16:0] err_count, sample_count;

  logic        r16_ready, r16_busy, r16_done, r16_sat;
  logic [15:0] r16_sum, r16_max;
  logic [7:0]  r16_wa, r16_wb;
  logic [16:0] r16_errc, r16_cnt;
`ifdef MUL8_ERR_MSE_EN
  logic [47:0] sq32;
  logic        sqs32;
  logic [31:0] sq16;
  logic        sqs16;
`endif

  mul8_err_monitor #(.SUM_W(32), .CNT_W(17)) dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_p(in_p),
    .busy(busy), .done(done), .sum_abs_err(sum_abs_err), .sum_sat(sum_sat),
    .max_abs_err(max_abs_err), .worst_a(worst_a), .worst_b(worst_b),
    .err_count(err_count),
`ifdef MUL8_ERR_MSE_EN
    .sum_sq_err(sq32), .sq_sat(sqs32),
`endif
    .sample_count(sample_count)
  );

  mul8_err_monitor #(.SUM_W(16), .CNT_W(17)) dut16 (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(r16_ready), .in_a(in_a), .in_b(in_b), .in_p(in_p),
    .busy(r16_busy), .done(r16_done), .sum_abs_err(r16_sum), .sum_sat(r16_sat),
    .max_abs_err(r16_max), .worst_a(r16_wa), .worst_b(r16_wb),
    .err_count(r16_errc),
`ifdef MUL8_ERR_MSE_EN
    .sum_sq_err(sq16), .sq_sat(sqs16),
`endif
    .sample_count(r16_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    longint sum32; bit sat32;
    longint sum16; bit sat16;
    int mx; int wa; int wb; int errc; int cnt;
  } exp_t;

  exp_t       exp_q[$];
  bit [7:0]   qa[$], qb[$];
  bit [15:0]  qp[$];
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string nm, input longint act, input longint expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Window statistics straight from the definition: |a*b - p| per sample.
  function automatic exp_t model();
    exp_t   r;
    longint tot = 0;
    r.mx = 0; r.wa = 0; r.wb = 0; r.errc = 0; r.cnt = 0;
    for (int i = 0; i < qa.size(); i++) begin
      int e;
      e = int'(qa[i]) * int'(qb[i]) - int'(qp[i]);
      if (e < 0) e = -e;
      tot += e;
      r.cnt++;
      if (e != 0) r.errc++;
      if (e > r.mx) begin r.mx = e; r.wa = qa[i]; r.wb = qb[i]; end
    end
    r.sat32 = (tot > 64'd4294967295);
    r.sum32 = r.sat32 ? 64'd4294967295 : tot;
    r.sat16 = (tot > 64'd65535);
    r.sum16 = r.sat16 ? 64'd65535 : tot;
    return r;
  endfunction

  // Monitor: whenever a window completes, compare against the oldest prediction.
  bit done_prev = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) done_prev = 1'b0;
      else begin
        if (done && !done_prev) begin
          if (exp_q.size() == 0) check("unexpected_done", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("sum_abs_err", sum_abs_err, e.sum32);
            check("sum_sat", sum_sat, e.sat32);
            check("max_abs_err", max_abs_err, e.mx);
            check("worst_a", worst_a, e.wa);
            check("worst_b", worst_b, e.wb);
            check("err_count", err_count, e.errc);
            check("sample_count", sample_count, e.cnt);
            check("sum16", r16_sum, e.sum16);
            check("sat16", r16_sat, e.sat16);
          end
        end
        done_prev = done;
      end
    end
  end

  task automatic clear_samples();
    qa.delete(); qb.delete(); qp.delete();
  endtask

  task automatic add(input int a, input int b, input int p);
    qa.push_back(8'(a)); qb.push_back(8'(b)); qp.push_back(16'(p));
  endtask

  task automatic pulse_start(input int n, output int start_cyc);
    @(posedge clk); #1;
    start = 1'b1; n_samples = 17'(n);
    @(negedge clk); start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_window(input int n, input bit rnd_valid, input bit poke_start);
    int start_cyc, last_acc, idx, budget, w;
    exp_q.push_back(model());
    pulse_start(n, start_cyc);
    idx = 0; budget = 0; last_acc = start_cyc;
    while (idx < n && budget < 4 * n + 100) begin
      in_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      in_a = qa[idx]; in_b = qb[idx]; in_p = qp[idx];
      if (poke_start && budget == 3) begin start = 1'b1; n_samples = 17'd1; end
      else start = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) begin idx++; last_acc = cyc; end
      budget++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (idx < n) check("handshake_timeout", idx, n);
    in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_p = 16'($urandom);
    check("in_ready_after_window", in_ready, 0);
    w = 0;
    do begin @(negedge clk); w++; end while (!done && w < 100);
    check("done_seen", done, 1);
    check("done_latency", cyc - last_acc, (n == 0) ? 2 : 3);
    repeat (2) @(negedge clk);
    check("held_in_done", sample_count, n);
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dummy;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; n_samples = '0;
    in_a = '0; in_b = '0; in_p = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum_abs_err, 0);
    check("rst_sat", sum_sat, 0);
    check("rst_max", max_abs_err, 0);
    check("rst_worst_a", worst_a, 0);
    check("rst_worst_b", worst_b, 0);
    check("rst_err_count", err_count, 0);
    check("rst_sample_count", sample_count, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Exhaustive sweep against an exact multiplier.
    clear_samples();
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 256; b++) add(a, b, a * b);
    run_window(65536, 1'b0, 1'b0);

    clear_samples();
    add(255, 255, 0); add(2, 3, 7); add(10, 10, 100);
    run_window(3, 1'b0, 1'b0);

    clear_samples();
    add(4, 4, 15); add(5, 5, 26);
    run_window(2, 1'b0, 1'b0);

    clear_samples();
    add(255, 255, 0); add(255, 255, 0);
    run_window(2, 1'b0, 1'b0);

    // Random valid gaps plus an ignored start mid-window.
    clear_samples();
    for (int i = 0; i < 5; i++)
      add($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 65535));
    run_window(5, 1'b1, 1'b1);

    for (int k = 0; k < 6; k++) begin
      int n;
      n = $urandom_range(1, 12);
      clear_samples();
      for (int i = 0; i < n; i++) begin
        int a, b, ex, p;
        a = $urandom_range(0, 255); b = $urandom_range(0, 255); ex = a * b;
        case ($urandom_range(0, 3))
          0: p = ex;
          1: p = ex + $urandom_range(0, 15);
          2: p = ex - $urandom_range(0, 15);
          default: p = $urandom_range(0, 65535);
        endcase
        add(a, b, p);
      end
      run_window(n, 1'b1, 1'b0);
    end

    // Reset in the middle of a window discards it.
    pulse_start(10, dummy);
    in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9; in_p = 16'd0;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_count_before_rst", sample_count, 2);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("mrst_in_ready", in_ready, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_sum", sum_abs_err, 0);
    check("mrst_max", max_abs_err, 0);
    check("mrst_err_count", err_count, 0);
    check("mrst_sample_count", sample_count, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("no_done_after_rst", done, 0);

    clear_samples();
    run_window(0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
